// File: rtl/fixed_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fixed_div_seq
// Purpose  : Sequential sign-magnitude fixed-point divider, Q(N-1-Q).Q format.
//            Restoring division produces one quotient bit per clock, MSB first.
//            Results are truncated toward zero and saturate on overflow or
//            divide-by-zero.
// Ports    : clk         - single clock, rising edge
//            reset       - synchronous, active-high
//            start       - divide request, sampled only while idle
//            a, b        - dividend / divisor (bit N-1 sign, N-2:0 magnitude)
//            out_ready   - consumer accepts the result held in DONE
//            c           - quotient, sign-magnitude
//            out_valid   - c and flags valid (state DONE)
//            busy        - state is not IDLE
//            div_by_zero - divisor magnitude was zero
//            overflow    - quotient magnitude did not fit in N-1 bits
// Revision : 1.0 - initial release
// ============================================================================
module fixed_div_seq #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         out_valid,
    output logic         busy,
    output logic         div_by_zero,
    output logic         overflow
);

    // Dividend {a_mag, Q zeros} is c_W bits wide; one iteration per bit.
    localparam int              c_W       = N - 1 + Q;
    localparam int              c_CW      = $clog2(c_W);
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(c_W - 1);
    localparam logic [N-2:0]    c_MAG_MAX = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_CW-1:0] r_cnt;
    logic [N-2:0]    r_divisor;
    logic [N-2:0]    r_rem;
    logic [c_W-1:0]  r_dq;      // dividend bits shift out the top, quotient bits in the bottom
    logic            r_sign;
    logic [N-1:0]    r_c;
    logic            r_ovf;
    logic            r_dbz;

    logic            w_b_zero;
    logic [N-1:0]    w_rem_sh;
    logic [N-2:0]    w_diff;
    logic            w_ge;
    logic [c_W-1:0]  w_q_final;
    logic            w_q_ovf;
    logic [N-2:0]    w_mag;

    assign w_b_zero  = (b[N-2:0] == '0);
    assign w_rem_sh  = {r_rem, r_dq[c_W-1]};
    // When w_ge holds the true difference is below the divisor, so the low
    // N-1 bits of the modular subtraction are exact.
    assign w_diff    = w_rem_sh[N-2:0] - r_divisor;
    assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    assign w_q_final = {r_dq[c_W-2:0], w_ge};
    assign w_q_ovf   = |w_q_final[c_W-1:N-1];
    assign w_mag     = w_q_ovf ? c_MAG_MAX : w_q_final[N-2:0];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_dq      <= '0;
            r_sign    <= 1'b0;
            r_c       <= '0;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_divisor <= b[N-2:0];
                        r_rem     <= '0;
                        r_dq      <= {a[N-2:0], {Q{1'b0}}};
                        r_sign    <= a[N-1] ^ b[N-1];
                        r_cnt     <= '0;
                        if (w_b_zero) begin
                            // Saturated magnitude is never zero, so the sign is kept.
                            r_c   <= {a[N-1] ^ b[N-1], c_MAG_MAX};
                            r_dbz <= 1'b1;
                            r_ovf <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff : w_rem_sh[N-2:0];
                    r_dq  <= w_q_final;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // Zero magnitude always reports a positive sign.
                        r_c   <= {(w_mag == '0) ? 1'b0 : r_sign, w_mag};
                        r_ovf <= w_q_ovf;
                        r_dbz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign c           = r_c;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
